operand_entry_fsm: RTL and testbench
====================================

// Module: operand_entry_fsm
// PURPOSE
//   Sequencer for the switch/button ALU calculator: captures operand A, operand B
//   and a 2-bit opcode from slide switches on successive Enter presses, then
//   computes and holds the result. Drives the state/opcode/result bus consumed
//   directly by the state-indicator LED stage and the display stage downstream.
// PARAMETERS
//   WIDTH            16   operand/result width in bits
//   DEBOUNCE_CYCLES  16   stable cycles required on Enter (DEBOUNCE_EN builds only), >=1
// PORTS
//   clk        in   1      system clock, all state on rising edge
//   reset_n    in   1      asynchronous active-low reset
//   enter      in   1      raw Enter pushbutton, asynchronous to clk
//   data_in    in   WIDTH  operand value from switches
//   op_in      in   2      opcode from switches
//   c_state    out  2      0=WAIT_A 1=WAIT_B 2=WAIT_OP 3=SHOW
//   OpCode     out  2      latched opcode
//   operand_a  out  WIDTH  latched operand A
//   operand_b  out  WIDTH  latched operand B
//   result     out  WIDTH  registered ALU result
// BEHAVIOUR
//   - Reset (async, while reset_n=0): c_state=0, OpCode=0, operand_a=operand_b=0,
//     result=0, sync/edge/debounce registers cleared. Reset mid-sequence aborts it.
//   - Enter conditioning: 2-FF synchroniser s1->s2, prev register p;
//     press = s2 & ~p (one-cycle pulse per rising edge). Held Enter = one press.
//     Latency: enter high before edge k -> c_state changes at edge k+2.
//   - FSM (acts only on cycles with press=1; otherwise all registers hold):
//     WAIT_A : operand_a <= data_in;                    -> WAIT_B
//     WAIT_B : operand_b <= data_in;                    -> WAIT_OP
//     WAIT_OP: OpCode <= op_in; result <= alu(op_in);   -> SHOW
//     SHOW   : operand_a, operand_b, result <= 0 (OpCode kept) -> WAIT_A
//   - alu uses current operand_a/operand_b and op_in same cycle:
//     0: a+b  1: a-b  2: a|b  3: a&b. Add/sub truncated mod 2^WIDTH
//     (two's-complement wrap, no carry/borrow output).
//   - result is valid whenever c_state==3; unchanged during SHOW regardless of
//     switch activity. data_in/op_in ignored except on the capturing press.
//   - Outputs are registered; no combinational path from inputs to outputs.
// CONFIGURATION
//   DEBOUNCE_EN defined: debounced level d follows s2 only after s2 differs from
//     d for DEBOUNCE_CYCLES consecutive cycles (counter clears on any agreement);
//     p tracks d and press = d & ~p. Glitches shorter than DEBOUNCE_CYCLES are
//     rejected; latency grows by DEBOUNCE_CYCLES. Counter cleared by reset.
//   DEBOUNCE_EN undefined: no counter, d == s2; Enter assumed bounce-free;
//     DEBOUNCE_CYCLES unused.
// TESTING
//   1 reset_n=0 mid-SHOW -> all outputs 0 immediately, c_state=0 after release.
//   2 presses with data_in=0x0005, 0x0003, op_in=0 -> c_state 0->1->2->3,
//     result=0x0008; op_in=1 run -> 0x0002; op_in=2 -> 0x0007; op_in=3 -> 0x0001.
//   3 A=0xFFFF, B=0x0002, op 0 -> result 0x0001; A=0x0000, B=0x0001, op 1 -> 0xFFFF.
//   4 enter held high 100 cycles in WAIT_A -> exactly one transition to WAIT_B;
//     enter rising before edge k -> c_state=1 from edge k+2 (non-debounced build).
//   5 in SHOW, toggle data_in/op_in freely -> result/OpCode unchanged; press ->
//     c_state=0, operands/result 0, OpCode retained.
//   6 DEBOUNCE_EN, DEBOUNCE_CYCLES=16: 5-cycle pulses on enter -> no transition;
//     clean 40-cycle press -> one transition after sync+16 cycles.

Source files
------------

// File: rtl/operand_entry_fsm.sv
// Enter-driven calculator sequencer: captures A, B and opcode, then holds ALU result until the next Enter.
// Latency: Enter edge to state change is 2 cycles, plus DEBOUNCE_CYCLES when built with `DEBOUNCE_EN.
// Backpressure: none; presses act immediately, and Enter held high counts as a single press.
module operand_entry_fsm #(
  parameter int WIDTH           = 16,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enter,
  input  logic [WIDTH-1:0] data_in,
  input  logic [1:0]       op_in,
  output logic [1:0]       c_state,
  output logic [1:0]       OpCode,
  output logic [WIDTH-1:0] operand_a,
  output logic [WIDTH-1:0] operand_b,
  output logic [WIDTH-1:0] result
);

  typedef enum logic [1:0] {
    WAIT_A  = 2'd0,
    WAIT_B  = 2'd1,
    WAIT_OP = 2'd2,
    SHOW    = 2'd3
  } state_t;

  if (DEBOUNCE_CYCLES < 1) begin : g_param_check
    $error("DEBOUNCE_CYCLES must be at least 1");
  end

  state_t           r_state;
  logic [1:0]       r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic             r_s1;
  logic             r_s2;
  logic             r_p;
  logic             w_level;
  logic             w_press;
  logic [WIDTH-1:0] w_alu;

  // Enter is asynchronous to clk; two flops before anything looks at it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= enter;
      r_s2 <= r_s1;
    end
  end

`ifdef DEBOUNCE_EN
  localparam int             CW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]  CMAX = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0]  CONE = CW'(1);

  logic          r_d;
  logic [CW-1:0] r_cnt;

  // Level only flips after DEBOUNCE_CYCLES straight cycles of disagreement.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_d   <= 1'b0;
      r_cnt <= '0;
    end else if (r_s2 == r_d) begin
      r_cnt <= '0;
    end else if (r_cnt == CMAX) begin
      r_d   <= r_s2;
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CONE;
    end
  end

  assign w_level = r_d;
`else
  assign w_level = r_s2;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_p <= 1'b0;
    else          r_p <= w_level;
  end

  assign w_press = w_level & ~r_p;

  always_comb begin
    w_alu = '0;
    case (op_in)
      2'd0:    w_alu = r_a + r_b;
      2'd1:    w_alu = r_a - r_b;
      2'd2:    w_alu = r_a | r_b;
      default: w_alu = r_a & r_b;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= WAIT_A;
      r_op    <= 2'd0;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
    end else if (w_press) begin
      case (r_state)
        WAIT_A: begin
          r_a     <= data_in;
          r_state <= WAIT_B;
        end
        WAIT_B: begin
          r_b     <= data_in;
          r_state <= WAIT_OP;
        end
        WAIT_OP: begin
          r_op    <= op_in;
          r_res   <= w_alu;
          r_state <= SHOW;
        end
        default: begin
          // Opcode stays visible after clearing so the display keeps the last operation.
          r_a     <= '0;
          r_b     <= '0;
          r_res   <= '0;
          r_state <= WAIT_A;
        end
      endcase
    end
  end

  assign c_state   = r_state;
  assign OpCode    = r_op;
  assign operand_a = r_a;
  assign operand_b = r_b;
  assign result    = r_res;

endmodule

// File: tb/tb_operand_entry_fsm.sv
// Randomized scoreboard bench for operand_entry_fsm; honours `DEBOUNCE_EN when the design is built with it.
module tb_operand_entry_fsm;

  localparam int W  = 16;
  localparam int DC = 16;
`ifdef DEBOUNCE_EN
  localparam int LAT = 2 + DC;
`else
  localparam int LAT = 2;
`endif

  typedef struct {
    logic [1:0]   st;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] r;
  } snap_t;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         enter;
  logic [W-1:0] data_in;
  logic [1:0]   op_in;
  logic [1:0]   c_state;
  logic [1:0]   OpCode;
  logic [W-1:0] operand_a;
  logic [W-1:0] operand_b;
  logic [W-1:0] result;

  int    checks   = 0;
  int    failures = 0;
  snap_t q[$];
  snap_t m;

  operand_entry_fsm #(.WIDTH(W), .DEBOUNCE_CYCLES(DC)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .enter     (enter),
    .data_in   (data_in),
    .op_in     (op_in),
    .c_state   (c_state),
    .OpCode    (OpCode),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .result    (result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic clear_model();
    m.st = 2'd0; m.op = 2'd0; m.a = '0; m.b = '0; m.r = '0;
  endtask

  // Reference: what one Enter press does to the visible calculator state.
  task automatic model_step(input logic [W-1:0] d, input logic [1:0] o, output snap_t e);
    int sum;
    case (m.st)
      2'd0: m.a = d;
      2'd1: m.b = d;
      2'd2: begin
        m.op = o;
        case (o)
          2'd0: begin sum = int'(m.a) + int'(m.b); m.r = W'(sum % 65536); end
          2'd1: begin sum = int'(m.a) - int'(m.b) + 65536; m.r = W'(sum % 65536); end
          2'd2: m.r = m.a | m.b;
          default: m.r = m.a & m.b;
        endcase
      end
      default: begin m.a = '0; m.b = '0; m.r = '0; end
    endcase
    m.st = (m.st == 2'd3) ? 2'd0 : m.st + 2'd1;
    e = m;
  endtask

  // Monitor: every state change must match the next queued expectation; otherwise outputs must hold.
  initial begin : monitor
    snap_t      cur;
    snap_t      e;
    logic [1:0] prev;
    cur.st = 0; cur.op = 0; cur.a = 0; cur.b = 0; cur.r = 0;
    prev = 2'd0;
    forever begin
      @(negedge clk);
      if (reset_n !== 1'b1) begin
        cur.st = 0; cur.op = 0; cur.a = 0; cur.b = 0; cur.r = 0;
        prev = c_state;
      end else if (c_state !== prev) begin
        if (q.size() == 0) begin
          chk("unexpected_transition", 64'(c_state), 64'(prev));
        end else begin
          e = q.pop_front();
          chk("trans_state", 64'(c_state), 64'(e.st));
          chk("trans_opcode", 64'(OpCode), 64'(e.op));
          chk("trans_a", 64'(operand_a), 64'(e.a));
          chk("trans_b", 64'(operand_b), 64'(e.b));
          chk("trans_result", 64'(result), 64'(e.r));
          cur = e;
        end
        prev = c_state;
      end else begin
        chk("hold_outputs", {12'd0, c_state, OpCode, operand_a, operand_b, result},
            {12'd0, cur.st, cur.op, cur.a, cur.b, cur.r});
      end
    end
  end

  task automatic press(input logic [W-1:0] d, input logic [1:0] o, input int hold);
    snap_t      e;
    logic [1:0] old_st;
    old_st = m.st;
    model_step(d, o, e);
    q.push_back(e);
    @(posedge clk); #1;
    data_in = d; op_in = o; enter = 1'b1;
    repeat (LAT) @(posedge clk);
    @(negedge clk);
    chk("latency_before", 64'(c_state), 64'(old_st));
    @(posedge clk);
    @(negedge clk);
    chk("latency_after", 64'(c_state), 64'(e.st));
    for (int i = LAT + 1; i < hold; i++) begin
      @(posedge clk); #1;
      data_in = W'($urandom); op_in = 2'($urandom);
    end
    @(posedge clk); #1;
    enter = 1'b0;
    repeat (LAT + 3) begin
      @(posedge clk); #1;
      data_in = W'($urandom); op_in = 2'($urandom);
    end
  endtask

  task automatic run_seq(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] o,
                         input logic [W-1:0] exp_res, input string name);
    press(a, 16'h1234, LAT + 2);
    press(b, 16'h4321, LAT + 2);
    press(16'hBEEF, o, LAT + 2);
    chk(name, 64'(result), 64'(exp_res));
    press(16'h0F0F, ~o, LAT + 2);
    chk("opcode_kept", 64'(OpCode), 64'(o));
    chk("cleared_result", 64'(result), 64'd0);
  endtask

  initial begin : stim
    clear_model();
    reset_n = 1'b0; enter = 1'b0; data_in = '0; op_in = 2'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {12'd0, c_state, OpCode, operand_a, operand_b, result}, 64'd0);
    reset_n = 1'b1;
    repeat (2) @(posedge clk);

    press(16'h0005, 2'd0, 100);
    chk("held_one_press", 64'(c_state), 64'd1);
    press(16'h0003, 2'd0, LAT + 2);
    press(16'h0000, 2'd0, LAT + 2);
    chk("add_5_3", 64'(result), 64'h0008);
    press(16'h0000, 2'd1, LAT + 2);

    run_seq(16'h0005, 16'h0003, 2'd1, 16'h0002, "sub_5_3");
    run_seq(16'h0005, 16'h0003, 2'd2, 16'h0007, "or_5_3");
    run_seq(16'h0005, 16'h0003, 2'd3, 16'h0001, "and_5_3");
    run_seq(16'hFFFF, 16'h0002, 2'd0, 16'h0001, "add_wrap");
    run_seq(16'h0000, 16'h0001, 2'd1, 16'hFFFF, "sub_wrap");

`ifdef DEBOUNCE_EN
    for (int g = 0; g < 4; g++) begin
      @(posedge clk); #1 enter = 1'b1;
      repeat (5) @(posedge clk);
      #1 enter = 1'b0;
      repeat (5) @(posedge clk);
    end
    repeat (DC + 4) @(posedge clk);
    #1;
    chk("glitch_rejected", 64'(c_state), 64'(m.st));
`endif

    for (int s = 0; s < 12; s++) begin
      for (int k = 0; k < 4; k++) begin
        press(W'($urandom), 2'($urandom), LAT + 1 + int'($urandom_range(0, 12)));
      end
    end

    press(16'h00A5, 2'd0, LAT + 2);
    press(16'h005A, 2'd0, LAT + 2);
    press(16'h0000, 2'd2, LAT + 5);
    chk("show_before_reset", 64'(c_state), 64'd3);
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    chk("reset_mid_show", {12'd0, c_state, OpCode, operand_a, operand_b, result}, 64'd0);
    clear_model();
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("state_after_reset", 64'(c_state), 64'd0);

    run_seq(16'h1111, 16'h2222, 2'd0, 16'h3333, "add_after_reset");

    repeat (LAT + 4) @(posedge clk);
    chk("queue_drained", 64'(q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
